// File: rtl/ws2812b_rx.sv
// WS2812B NRZ line decoder: recovers GRB pixels and frame boundaries from pulse widths.
// Optional error reporting is enabled by defining WS2812B_RX_ERR_EN.
module ws2812b_rx #(
    parameter int T_MIN_HIGH = 4,
    parameter int T_THRESH   = 30,
    parameter int T_MAX_LOW  = 100,
    parameter int T_RESET    = 2500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic [15:0] pixel_index,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic [15:0] frame_pixels,
    output logic        busy,
    output logic        err
);

    localparam logic [15:0] MIN_H  = 16'(T_MIN_HIGH);
    localparam logic [15:0] THRESH = 16'(T_THRESH);
    localparam logic [15:0] RST_N  = 16'(T_RESET);
    localparam logic [15:0] RST_M1 = 16'(T_RESET - 1);

    typedef enum logic [1:0] {WAIT_RST, IDLE, HIGH, LOW} state_t;

    state_t      state, state_n;
    logic        din_s1, din_s2;
    logic [15:0] hi_cnt, hi_n;
    logic [15:0] lo_cnt, lo_n;
    logic [23:0] sr, sr_n;
    logic [4:0]  bit_cnt, bc_n;
    logic [15:0] idx, idx_n;
    logic        in_frame, inf_n;
    logic [23:0] pd_n;
    logic [15:0] pi_n, fp_n;
    logic        pv_n, fd_n;
    logic        bit_val;
`ifdef WS2812B_RX_ERR_EN
    localparam logic [15:0] MAX_L = 16'(T_MAX_LOW);
    logic        err_n;
`endif

    assign bit_val = (hi_cnt >= THRESH);
    assign busy    = (state == HIGH) || (state == LOW);

    always_comb begin
        state_n = state;
        hi_n    = hi_cnt;
        lo_n    = lo_cnt;
        sr_n    = sr;
        bc_n    = bit_cnt;
        idx_n   = idx;
        inf_n   = in_frame;
        pd_n    = pixel_data;
        pi_n    = pixel_index;
        fp_n    = frame_pixels;
        pv_n    = 1'b0;
        fd_n    = 1'b0;
`ifdef WS2812B_RX_ERR_EN
        err_n   = 1'b0;
`endif
        unique case (state)
            // Only a full reset-length low gap proves we are aligned to a pixel boundary.
            WAIT_RST: begin
                if (din_s2) begin
                    lo_n = 16'd0;
                end else if (lo_cnt == RST_M1) begin
                    lo_n    = 16'd0;
                    state_n = IDLE;
                end else begin
                    lo_n = lo_cnt + 16'd1;
                end
            end
            IDLE: begin
                if (din_s2) begin
                    hi_n    = 16'd1;
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (din_s2) begin
                    if (hi_cnt != 16'hFFFF) hi_n = hi_cnt + 16'd1;
                end else if (hi_cnt < MIN_H) begin
                    // Glitch: lo_cnt is left running so the surrounding gap is measured whole.
                    state_n = in_frame ? LOW : IDLE;
`ifdef WS2812B_RX_ERR_EN
                    err_n   = 1'b1;
`endif
                end else begin
                    sr_n    = {sr[22:0], bit_val};
                    inf_n   = 1'b1;
                    lo_n    = 16'd1;
                    state_n = LOW;
                    if (bit_cnt == 5'd23) begin
                        pd_n  = {sr[22:0], bit_val};
                        pi_n  = idx;
                        pv_n  = 1'b1;
                        idx_n = idx + 16'd1;
                        bc_n  = 5'd0;
                    end else begin
                        bc_n = bit_cnt + 5'd1;
                    end
`ifdef WS2812B_RX_ERR_EN
                    if (hi_cnt > MAX_L) err_n = 1'b1;
`endif
                end
            end
            LOW: begin
                if (din_s2) begin
                    hi_n    = 16'd1;
                    state_n = HIGH;
`ifdef WS2812B_RX_ERR_EN
                    if (lo_cnt > MAX_L) err_n = 1'b1;
`endif
                end else if (lo_cnt == RST_N) begin
                    fp_n    = idx;
                    fd_n    = 1'b1;
                    idx_n   = 16'd0;
                    bc_n    = 5'd0;
                    sr_n    = 24'd0;
                    inf_n   = 1'b0;
                    lo_n    = 16'd0;
                    state_n = IDLE;
`ifdef WS2812B_RX_ERR_EN
                    if (bit_cnt != 5'd0) err_n = 1'b1;
`endif
                end else begin
                    lo_n = lo_cnt + 16'd1;
                end
            end
            default: state_n = WAIT_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_s1       <= 1'b0;
            din_s2       <= 1'b0;
            state        <= WAIT_RST;
            hi_cnt       <= 16'd0;
            lo_cnt       <= 16'd0;
            sr           <= 24'd0;
            bit_cnt      <= 5'd0;
            idx          <= 16'd0;
            in_frame     <= 1'b0;
            pixel_data   <= 24'd0;
            pixel_index  <= 16'd0;
            pixel_valid  <= 1'b0;
            frame_done   <= 1'b0;
            frame_pixels <= 16'd0;
        end else begin
            din_s1       <= din;
            din_s2       <= din_s1;
            state        <= state_n;
            hi_cnt       <= hi_n;
            lo_cnt       <= lo_n;
            sr           <= sr_n;
            bit_cnt      <= bc_n;
            idx          <= idx_n;
            in_frame     <= inf_n;
            pixel_data   <= pd_n;
            pixel_index  <= pi_n;
            pixel_valid  <= pv_n;
            frame_done   <= fd_n;
            frame_pixels <= fp_n;
        end
    end

`ifdef WS2812B_RX_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err <= 1'b0;
        else          err <= err_n;
    end
`else
    assign err = 1'b0;
`endif

endmodule
